// File: rtl/dsi_packet_assembler.sv
// DSI packet assembler: turns command + payload streams into 32-bit header/payload/CRC
// words for the lanes controller write port, with header ECC and payload CRC-16.
module dsi_packet_assembler (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic [7:0]  pkt_data_id,
    input  logic [15:0] pkt_word_count,
    input  logic        pkt_long,
    input  logic        pkt_lp_mode,
    input  logic [31:0] pld_data,
    input  logic        pld_valid,
    output logic        pld_ready,
    output logic [31:0] iface_write_data,
    output logic [4:0]  iface_write_strb,
    output logic        iface_write_rqst,
    output logic        iface_last_word,
    input  logic        iface_data_rqst,
    output logic        busy,
    output logic        underflow_err
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PLD, S_CRC} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_hdr;
    logic        r_long;
    logic        r_lp;
    logic [15:0] r_wc;
    logic [15:0] r_rem;        // bytes still to be sent
    logic [15:0] r_fetch_rem;  // bytes still to be pulled from pld_*
    logic [31:0] r_pf_data;
    logic        r_pf_valid;
    logic [15:0] r_crc;
    logic        r_uf_prev;

    logic        w_pf_take;
    logic        w_fetch;
    logic        w_consume;
    logic        w_accept;
    logic        w_uf_cond;
    logic [15:0] w_fetch_n;
    logic [15:0] w_rem_n;

    function automatic logic [5:0] ecc6(input logic [23:0] h);
        logic [5:0] p;
        p[0] = ^{h[0], h[1], h[2], h[4], h[5], h[7], h[10], h[11], h[13], h[16],
                 h[20], h[21], h[22], h[23]};
        p[1] = ^{h[0], h[1], h[3], h[4], h[6], h[8], h[10], h[12], h[14], h[17],
                 h[20], h[21], h[22], h[23]};
        p[2] = ^{h[0], h[2], h[3], h[5], h[6], h[9], h[11], h[12], h[15], h[18],
                 h[20], h[21], h[22]};
        p[3] = ^{h[1], h[2], h[3], h[7], h[8], h[9], h[13], h[14], h[15], h[19],
                 h[20], h[21], h[23]};
        p[4] = ^{h[4], h[5], h[6], h[7], h[8], h[9], h[16], h[17], h[18], h[19],
                 h[20], h[22], h[23]};
        p[5] = ^{h[19:10], h[21], h[22], h[23]};
        return p;
    endfunction

    // Reflected CRC-16 (0x8408), first n bytes of d, LSB of each byte first.
    function automatic logic [15:0] crc_bytes(input logic [15:0] crc, input logic [31:0] d,
                                              input logic [2:0] n);
        logic [15:0] c;
        c = crc;
        for (int b = 0; b < 4; b++) begin
            if (b < int'(n)) begin
                for (int k = 0; k < 8; k++) begin
                    c = (c[0] ^ d[8*b+k]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
                end
            end
        end
        return c;
    endfunction

    assign w_fetch_n = (r_fetch_rem > 16'd4) ? 16'd4 : r_fetch_rem;
    assign w_rem_n   = (r_rem > 16'd4) ? 16'd4 : r_rem;

    assign busy             = (r_state != S_IDLE);
    assign iface_write_rqst = busy;
    assign w_pf_take  = (r_state == S_PLD) && r_pf_valid && iface_data_rqst;
    assign pld_ready  = busy && (r_fetch_rem != 16'd0) && (!r_pf_valid || w_pf_take);
    assign w_fetch    = pld_ready && pld_valid;
    assign w_consume  = iface_write_rqst && iface_data_rqst && ((r_state != S_PLD) || r_pf_valid);
    // A new command can slip in on the same cycle the last word leaves.
    assign pkt_ready  = (r_state == S_IDLE) || (w_consume && iface_last_word);
    assign w_accept   = pkt_valid && pkt_ready;
    assign w_uf_cond  = (r_state == S_PLD) && iface_data_rqst && !r_pf_valid;
    assign underflow_err = w_uf_cond && !r_uf_prev;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: w_state_nxt = S_IDLE;
            S_HDR: if (w_consume)
                w_state_nxt = !r_long ? S_IDLE : ((r_wc == 16'd0) ? S_CRC : S_PLD);
            S_PLD: if (w_consume && r_rem <= 16'd4)
                w_state_nxt = (r_rem <= 16'd2) ? S_IDLE : S_CRC;
            S_CRC: if (w_consume) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_accept) w_state_nxt = S_HDR;
    end

    always_comb begin
        iface_write_data = 32'h0;
        iface_write_strb = 5'h0;
        iface_last_word  = 1'b0;
        case (r_state)
            S_HDR: begin
                iface_write_data = r_hdr;
                iface_write_strb = {r_lp, 4'hF};
                iface_last_word  = !r_long;
            end
            S_PLD: if (r_pf_valid) begin
                if (r_rem >= 16'd4) begin
                    iface_write_data = r_pf_data;
                    iface_write_strb = {r_lp, 4'hF};
                end else begin
                    case (r_rem[1:0])
                        2'd3: begin
                            iface_write_data = {r_crc[7:0], r_pf_data[23:0]};
                            iface_write_strb = {r_lp, 4'hF};
                        end
                        2'd2: begin
                            iface_write_data = {r_crc, r_pf_data[15:0]};
                            iface_write_strb = {r_lp, 4'hF};
                            iface_last_word  = 1'b1;
                        end
                        default: begin
                            iface_write_data = {8'h0, r_crc, r_pf_data[7:0]};
                            iface_write_strb = {r_lp, 4'h7};
                            iface_last_word  = 1'b1;
                        end
                    endcase
                end
            end
            S_CRC: begin
                // WC mod 4 == 3 already carried the CRC low byte in the last payload word.
                if (r_wc[1:0] == 2'd3) begin
                    iface_write_data = {24'h0, r_crc[15:8]};
                    iface_write_strb = {r_lp, 4'h1};
                end else begin
                    iface_write_data = {16'h0, r_crc};
                    iface_write_strb = {r_lp, 4'h3};
                end
                iface_last_word = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_hdr       <= 32'h0;
            r_long      <= 1'b0;
            r_lp        <= 1'b0;
            r_wc        <= 16'h0;
            r_rem       <= 16'h0;
            r_fetch_rem <= 16'h0;
            r_pf_data   <= 32'h0;
            r_pf_valid  <= 1'b0;
            r_crc       <= 16'hFFFF;
            r_uf_prev   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_uf_prev <= w_uf_cond;
            if (w_accept) begin
                r_hdr       <= {2'b00, ecc6({pkt_word_count, pkt_data_id}), pkt_word_count, pkt_data_id};
                r_long      <= pkt_long;
                r_lp        <= pkt_lp_mode;
                r_wc        <= pkt_word_count;
                r_rem       <= pkt_long ? pkt_word_count : 16'h0;
                r_fetch_rem <= pkt_long ? pkt_word_count : 16'h0;
                r_crc       <= 16'hFFFF;
                r_pf_valid  <= 1'b0;
            end else begin
                // CRC tracks fetched bytes, so it is final by the time the tail word is shown.
                if (w_fetch) begin
                    r_pf_data   <= pld_data;
                    r_pf_valid  <= 1'b1;
                    r_fetch_rem <= r_fetch_rem - w_fetch_n;
                    r_crc       <= crc_bytes(r_crc, pld_data, w_fetch_n[2:0]);
                end else if (w_pf_take) begin
                    r_pf_valid <= 1'b0;
                end
                if (w_pf_take) r_rem <= r_rem - w_rem_n;
            end
        end
    end

endmodule

// File: tb/tb_dsi_packet_assembler.sv
// Directed bench for dsi_packet_assembler: ECC, CRC, tail packing, stalls, underflow, reset.
module tb_dsi_packet_assembler;

    logic        clk_sys;
    logic        rst_n;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [7:0]  pkt_data_id;
    logic [15:0] pkt_word_count;
    logic        pkt_long;
    logic        pkt_lp_mode;
    logic [31:0] pld_data;
    logic        pld_valid;
    logic        pld_ready;
    logic [31:0] iface_write_data;
    logic [4:0]  iface_write_strb;
    logic        iface_write_rqst;
    logic        iface_last_word;
    logic        iface_data_rqst;
    logic        busy;
    logic        underflow_err;

    int n_cmp;
    int n_bad;

    wire [42:0] w_outs = {pkt_ready, pld_ready, iface_write_data, iface_write_strb,
                          iface_write_rqst, iface_last_word, busy, underflow_err};
    localparam logic [42:0] RST_OUTS = {1'b1, 42'h0};

    dsi_packet_assembler dut (
        .clk_sys         (clk_sys),
        .rst_n           (rst_n),
        .pkt_valid       (pkt_valid),
        .pkt_ready       (pkt_ready),
        .pkt_data_id     (pkt_data_id),
        .pkt_word_count  (pkt_word_count),
        .pkt_long        (pkt_long),
        .pkt_lp_mode     (pkt_lp_mode),
        .pld_data        (pld_data),
        .pld_valid       (pld_valid),
        .pld_ready       (pld_ready),
        .iface_write_data(iface_write_data),
        .iface_write_strb(iface_write_strb),
        .iface_write_rqst(iface_write_rqst),
        .iface_last_word (iface_last_word),
        .iface_data_rqst (iface_data_rqst),
        .busy            (busy),
        .underflow_err   (underflow_err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] ref_ecc(input logic [23:0] h);
        return {2'b00, ^(h & 24'hEFFC00), ^(h & 24'hDF03F0), ^(h & 24'hB8E38E),
                ^(h & 24'h749A6D), ^(h & 24'hF2555B), ^(h & 24'hF12CB7)};
    endfunction

    function automatic logic [15:0] ref_crc(input logic [7:0] pl[$], input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {8'h00, pl[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    // Drives one packet and collects consumed words as {strb, last, data}.
    task automatic run_pkt(
        input  logic [7:0]  di, input logic [15:0] wc, input logic lng, input logic lp,
        input  logic [7:0]  pl[$], input bit rnd_rqst, input int stall_from, input int stall_len,
        output logic [37:0] words[$], output int uf_cnt, output int unstable, output int lat,
        output bit idle_after, output bit timeout);
        int nw, pidx, c_acc;
        bit sent, pending;
        logic [37:0] cur, prev;
        logic [31:0] w;
        words = {}; uf_cnt = 0; unstable = 0; lat = -1; timeout = 1'b1;
        sent = 1'b0; pending = 1'b0; pidx = 0; c_acc = 0; prev = '0;
        nw = lng ? (int'(wc) + 3) / 4 : 0;
        for (int c = 0; c < 300 && timeout; c++) begin
            @(negedge clk_sys);
            pkt_valid = !sent; pkt_data_id = di; pkt_word_count = wc;
            pkt_long = lng; pkt_lp_mode = lp;
            for (int k = 0; k < 4; k++)
                w[8*k +: 8] = (pidx*4 + k < int'(pl.size())) ? pl[pidx*4 + k] : 8'hEE;
            pld_data = w;
            pld_valid = (pidx < nw) && !(c >= stall_from && c < stall_from + stall_len);
            iface_data_rqst = rnd_rqst ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (underflow_err) uf_cnt++;
            if (iface_write_rqst && lat < 0) lat = c - c_acc;
            cur = {iface_write_strb, iface_last_word, iface_write_data};
            if (pending && cur !== prev) unstable++;
            pending = 1'b0;
            if (iface_write_rqst && iface_write_strb[3:0] != 4'h0) begin
                if (iface_data_rqst) begin
                    words.push_back(cur);
                    if (iface_last_word) timeout = 1'b0;
                end else pending = 1'b1;
            end
            prev = cur;
            if (pkt_valid && pkt_ready) begin sent = 1'b1; c_acc = c; end
            if (pld_valid && pld_ready) pidx++;
        end
        @(negedge clk_sys);
        pkt_valid = 1'b0; pld_valid = 1'b0; iface_data_rqst = 1'b0;
        #1;
        idle_after = !iface_write_rqst && !busy;
    endtask

    task automatic mk_long9(output logic [7:0] pl[$], output logic [37:0] e[$]);
        pl = {};
        for (int i = 0; i < 9; i++) pl.push_back(8'(8'h31 + i));
        e = {};
        e.push_back({5'b01111, 1'b0, 32'h23000929});
        e.push_back({5'b01111, 1'b0, 32'h34333231});
        e.push_back({5'b01111, 1'b0, 32'h38373635});
        e.push_back({5'b00111, 1'b1, 32'h006F9139});
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (w_outs !== RST_OUTS) begin
            n_bad++; $display("FAIL reset_outs: got %h want %h", w_outs, RST_OUTS);
        end
        @(negedge clk_sys);
        rst_n = 1'b1;
    endtask

    task automatic test_short;
        logic [7:0] pl[$]; logic [37:0] got[$];
        int uf, uns, lat; bit idl, to;
        pl = {};
        run_pkt(8'h05, 16'h0011, 1'b0, 1'b1, pl, 1'b0, 0, 0, got, uf, uns, lat, idl, to);
        n_cmp++;
        if (to || got.size() != 1) begin
            n_bad++; $display("FAIL short_count: got %0d words to=%0d want 1", got.size(), to);
        end else begin
            n_cmp++;
            if (got[0] !== {5'b11111, 1'b1, 32'h36001105}) begin
                n_bad++; $display("FAIL short_word: got %h want %h", got[0], {5'b11111, 1'b1, 32'h36001105});
            end
        end
        n_cmp++;
        if (lat !== 1) begin n_bad++; $display("FAIL short_latency: got %0d want 1", lat); end
        n_cmp++;
        if (idl !== 1'b1) begin n_bad++; $display("FAIL short_idle_after: got %0d want 1", idl); end
    endtask

    task automatic test_ecc;
        logic [7:0] pl[$]; logic [37:0] got[$];
        int uf, uns, lat; bit idl, to;
        logic [23:0] hv[3];
        logic [31:0] ev[3];
        hv[0] = 24'h000000; ev[0] = 32'h00000000;
        hv[1] = 24'h000001; ev[1] = 32'h07000001;
        hv[2] = 24'h800000; ev[2] = 32'h3B800000;
        pl = {};
        for (int i = 0; i < 3; i++) begin
            run_pkt(hv[i][7:0], hv[i][23:8], 1'b0, 1'b0, pl, 1'b0, 0, 0, got, uf, uns, lat, idl, to);
            n_cmp++;
            if (to || got.size() != 1 || got[0][31:0] !== ev[i]) begin
                n_bad++; $display("FAIL ecc_%0d: got %h want %h", i,
                                  (got.size() > 0) ? got[0][31:0] : 32'hx, ev[i]);
            end
        end
    endtask

    task automatic test_long9;
        logic [7:0] pl[$]; logic [37:0] got[$], e[$];
        int uf, uns, lat; bit idl, to;
        mk_long9(pl, e);
        run_pkt(8'h29, 16'd9, 1'b1, 1'b0, pl, 1'b0, 0, 0, got, uf, uns, lat, idl, to);
        n_cmp++;
        if (to || got.size() != e.size()) begin
            n_bad++; $display("FAIL long9_count: got %0d want %0d", got.size(), e.size());
        end
        for (int i = 0; i < e.size() && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== e[i]) begin n_bad++; $display("FAIL long9_w%0d: got %h want %h", i, got[i], e[i]); end
        end
        n_cmp++;
        if (ref_crc(pl, 9) !== 16'h6F91) begin
            n_bad++; $display("FAIL long9_refcrc: got %h want 6f91", ref_crc(pl, 9));
        end
        n_cmp++;
        if (idl !== 1'b1) begin n_bad++; $display("FAIL long9_idle_after: got %0d want 1", idl); end
    endtask

    task automatic test_long0(input string tag);
        logic [7:0] pl[$]; logic [37:0] got[$], e[$];
        int uf, uns, lat; bit idl, to;
        pl = {};
        e = {};
        e.push_back({5'b01111, 1'b0, 32'h1C000029});
        e.push_back({5'b00011, 1'b1, 32'h0000FFFF});
        run_pkt(8'h29, 16'd0, 1'b1, 1'b0, pl, 1'b0, 0, 0, got, uf, uns, lat, idl, to);
        n_cmp++;
        if (to || got.size() != 2) begin
            n_bad++; $display("FAIL %s_count: got %0d want 2", tag, got.size());
        end
        for (int i = 0; i < 2 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== e[i]) begin n_bad++; $display("FAIL %s_w%0d: got %h want %h", tag, i, got[i], e[i]); end
        end
    endtask

    task automatic test_tail_mod;
        logic [7:0] pl[$]; logic [37:0] got[$], e[$];
        int uf, uns, lat; bit idl, to;
        logic [15:0] c;
        logic [15:0] wcs[2];
        wcs[0] = 16'd7; wcs[1] = 16'd8;
        for (int t = 0; t < 2; t++) begin
            pl = {};
            for (int i = 0; i < int'(wcs[t]); i++) pl.push_back(8'((t == 0 ? 8'h11 : 8'h01) + i));
            c = ref_crc(pl, int'(wcs[t]));
            e = {};
            e.push_back({5'b01111, 1'b0, ref_ecc({wcs[t], 8'h29}), wcs[t], 8'h29});
            e.push_back({5'b01111, 1'b0, pl[3], pl[2], pl[1], pl[0]});
            if (t == 0) begin
                e.push_back({5'b01111, 1'b0, c[7:0], pl[6], pl[5], pl[4]});
                e.push_back({5'b00001, 1'b1, 24'h0, c[15:8]});
            end else begin
                e.push_back({5'b01111, 1'b0, pl[7], pl[6], pl[5], pl[4]});
                e.push_back({5'b00011, 1'b1, 16'h0, c});
            end
            run_pkt(8'h29, wcs[t], 1'b1, 1'b0, pl, 1'b0, 0, 0, got, uf, uns, lat, idl, to);
            n_cmp++;
            if (to || got.size() != e.size()) begin
                n_bad++; $display("FAIL tail_wc%0d_count: got %0d want %0d", wcs[t], got.size(), e.size());
            end
            for (int i = 0; i < e.size() && i < got.size(); i++) begin
                n_cmp++;
                if (got[i] !== e[i]) begin
                    n_bad++; $display("FAIL tail_wc%0d_w%0d: got %h want %h", wcs[t], i, got[i], e[i]);
                end
            end
        end
    endtask

    task automatic test_stall;
        logic [7:0] pl[$]; logic [37:0] got[$], e[$];
        int uf, uns, lat; bit idl, to;
        mk_long9(pl, e);
        run_pkt(8'h29, 16'd9, 1'b1, 1'b0, pl, 1'b1, 0, 0, got, uf, uns, lat, idl, to);
        n_cmp++;
        if (to || got.size() != e.size()) begin
            n_bad++; $display("FAIL stall_count: got %0d want %0d", got.size(), e.size());
        end
        for (int i = 0; i < e.size() && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== e[i]) begin n_bad++; $display("FAIL stall_w%0d: got %h want %h", i, got[i], e[i]); end
        end
        n_cmp++;
        if (uns !== 0) begin n_bad++; $display("FAIL stall_stable: got %0d changes want 0", uns); end
    endtask

    task automatic test_underflow;
        logic [7:0] pl[$]; logic [37:0] got[$], e[$];
        int uf, uns, lat; bit idl, to;
        mk_long9(pl, e);
        run_pkt(8'h29, 16'd9, 1'b1, 1'b0, pl, 1'b0, 2, 3, got, uf, uns, lat, idl, to);
        n_cmp++;
        if (uf !== 1) begin n_bad++; $display("FAIL underflow_pulses: got %0d want 1", uf); end
        n_cmp++;
        if (to || got.size() != e.size()) begin
            n_bad++; $display("FAIL underflow_count: got %0d want %0d", got.size(), e.size());
        end
        for (int i = 0; i < e.size() && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== e[i]) begin n_bad++; $display("FAIL underflow_w%0d: got %h want %h", i, got[i], e[i]); end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk_sys);
        pkt_valid = 1'b1; pkt_data_id = 8'h01; pkt_word_count = 16'h0000;
        pkt_long = 1'b0; pkt_lp_mode = 1'b0; pld_valid = 1'b0; iface_data_rqst = 1'b1;
        #1;
        n_cmp++;
        if (pkt_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready0: got %0d want 1", pkt_ready); end
        @(negedge clk_sys);
        pkt_data_id = 8'h05; pkt_word_count = 16'h0011;
        #1;
        n_cmp++;
        if ({iface_write_rqst, iface_last_word, pkt_ready, iface_write_data} !== {3'b111, 32'h07000001}) begin
            n_bad++; $display("FAIL b2b_first: got %b %h want 111 07000001",
                              {iface_write_rqst, iface_last_word, pkt_ready}, iface_write_data);
        end
        @(negedge clk_sys);
        pkt_valid = 1'b0;
        #1;
        n_cmp++;
        if ({iface_write_rqst, iface_last_word, iface_write_data} !== {2'b11, 32'h36001105}) begin
            n_bad++; $display("FAIL b2b_second: got %b %h want 11 36001105",
                              {iface_write_rqst, iface_last_word}, iface_write_data);
        end
        @(negedge clk_sys);
        iface_data_rqst = 1'b0;
        #1;
        n_cmp++;
        if ({iface_write_rqst, busy} !== 2'b00) begin
            n_bad++; $display("FAIL b2b_idle: got %b want 00", {iface_write_rqst, busy});
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk_sys);
        pkt_valid = 1'b1; pkt_data_id = 8'h29; pkt_word_count = 16'd9;
        pkt_long = 1'b1; pkt_lp_mode = 1'b1; pld_valid = 1'b1; pld_data = 32'h34333231;
        iface_data_rqst = 1'b1;
        @(negedge clk_sys);
        pkt_valid = 1'b0;
        @(negedge clk_sys);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy: got %0d want 1", busy); end
        pld_valid = 1'b0; iface_data_rqst = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (w_outs !== RST_OUTS) begin
            n_bad++; $display("FAIL rstmid_outs: got %h want %h", w_outs, RST_OUTS);
        end
        @(negedge clk_sys);
        rst_n = 1'b1;
        test_long0("rstmid_recover");
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; pkt_valid = 1'b0; pkt_data_id = 8'h0; pkt_word_count = 16'h0;
        pkt_long = 1'b0; pkt_lp_mode = 1'b0; pld_data = 32'h0; pld_valid = 1'b0;
        iface_data_rqst = 1'b0;
        repeat (2) @(negedge clk_sys);
        test_reset;
        test_short;
        test_ecc;
        test_long9;
        test_long0("long0");
        test_tail_mod;
        test_stall;
        test_underflow;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
